// File: rtl/demux_route_ctrl.sv
// Sequencer for the 1-to-3 routing demux: splits one valid/ready word stream into three
// back-to-back segments of programmed length and drives select, strobes and addresses.
module demux_route_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] len0,
    input  logic [ADDR_W-1:0] len1,
    input  logic [ADDR_W-1:0] len2,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] data_out,
    output logic [2:0]        wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEG0 = 3'd1,
        SEG1 = 3'd2,
        SEG2 = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] lat0, lat1, lat2;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cur_len;
    logic [1:0]        seg;
    logic              in_seg;
    logic              accept;
    logic              last;

    // First segment at index k or later with a nonzero length, else FIN
    function automatic state_t seg_from(input logic [1:0] k, input logic [ADDR_W-1:0] a,
                                        input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
        if (k == 2'd0 && a != '0) return SEG0;
        if (k <= 2'd1 && b != '0) return SEG1;
        if (k <= 2'd2 && c != '0) return SEG2;
        return FIN;
    endfunction

    always_comb begin
        in_seg  = 1'b0;
        seg     = 2'd0;
        cur_len = lat0;
        case (state)
            SEG0: begin in_seg = 1'b1; seg = 2'd0; cur_len = lat0; end
            SEG1: begin in_seg = 1'b1; seg = 2'd1; cur_len = lat1; end
            SEG2: begin in_seg = 1'b1; seg = 2'd2; cur_len = lat2; end
            default: ;
        endcase
    end

    assign in_ready = in_seg && !abort;
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == cur_len - ADDR_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lat0     <= '0;
            lat1     <= '0;
            lat2     <= '0;
            cnt      <= '0;
            sel      <= 2'd3;
            data_out <= '0;
            wr_en    <= '0;
            wr_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            wr_en <= '0;
            done  <= 1'b0;
            // Accepted word appears on the demux one cycle later
            if (accept) begin
                wr_en    <= 3'b001 << seg;
                sel      <= seg;
                data_out <= in_data;
                wr_addr  <= cnt;
            end
            case (state)
                IDLE: begin
                    sel <= 2'd3;
                    if (start && !abort) begin
                        lat0  <= len0;
                        lat1  <= len1;
                        lat2  <= len2;
                        busy  <= 1'b1;
                        state <= seg_from(2'd0, len0, len1, len2);
                    end
                end
                SEG0, SEG1, SEG2: begin
                    if (abort) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        sel   <= 2'd3;
                        state <= IDLE;
                    end else if (accept) begin
                        if (last) begin
                            cnt   <= '0;
                            state <= seg_from(2'(seg + 2'd1), lat0, lat1, lat2);
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    sel   <= 2'd3;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
